bus_hub_n: RTL and testbench
============================

Name: bus_hub_n

Overview:
- Parametrised N-device successor to the two-device bus hub.
- Connects one host bus (the CPU data port) to NDEV memory-mapped devices, one transaction at a time.
- Devices self-decode the broadcast address through their device_active outputs; the hub picks a target, runs the handshake and returns a registered response.
- New behaviour: lowest-index priority on overlapping decode, error response for unmapped addresses, per-transaction timeout, and a saturating error counter.

Parameters:
- NDEV, 4, number of device ports (2..16).
- TIMEOUT, 64, cycles allowed from device strobe to device_ready before an error response; 0 disables the timeout.
- ERRW, 8, width of the error counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- host_address  in  32  byte address.
- host_data_write  in  32  write data.
- host_write_mask  in  4  byte enables.
- host_wen  in  1  write request.
- host_ren  in  1  read request.
- host_data_read  out  32  read data; valid while host_ready is high.
- host_ready  out  1  one-cycle completion pulse.
- host_error  out  1  qualifies host_ready: unmapped address or timeout.
- device_address  out  NDEV*32  address, broadcast to every slice.
- device_data_write  out  NDEV*32  write data, broadcast.
- device_write_mask  out  NDEV*4  byte enables, broadcast.
- device_ren  out  NDEV  read strobe; only the selected bit can be high.
- device_wen  out  NDEV  write strobe; only the selected bit can be high.
- device_ready  in  NDEV  per-device completion.
- device_data_read  in  NDEV*32  per-device read data.
- device_active  in  NDEV  per-device decode hit for the current device_address.
- err_count  out  ERRW  saturating count of error responses.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; all strobes 0; host_ready=0; host_error=0; host_data_read=0; err_count=0; latches=0.
  - Reset asserted mid-transaction abandons it; no host_ready is issued.
- Address broadcast: device_address/data/mask = live host inputs in IDLE, latched values otherwise.
- IDLE:
  - Advances when host_ren|host_wen. If both are high, treat as a write.
  - Latch address, data, mask, op and sel, where sel = lowest i with device_active[i] set.
  - If no device is active, go to RESP with error=1, rdata=0.
  - Otherwise go to BUSY and clear the timer.
- BUSY:
  - device_ren[sel] or device_wen[sel] is held high, starting the cycle after capture.
  - On device_ready[sel]=1: latch device_data_read[sel] (writes latch 0), drop the strobe the next cycle, go to RESP with error=0.
  - device_ready on any other index is ignored.
  - The timer increments each BUSY cycle. If TIMEOUT≠0 and the timer reaches TIMEOUT-1 without ready, drop the strobe and go to RESP with error=1, rdata=0.
  - device_ready arriving in the same cycle the timeout expires counts as success.
- RESP:
  - host_ready=1 for exactly one cycle, with host_data_read and host_error from the latches; then go to IDLE.
  - If error, err_count increments, saturating at all-ones.
  - host_data_read returns to 0 when host_ready is low.
- Host rules:
  - The host holds request and data stable until host_ready.
  - Host inputs are sampled only in IDLE.
  - A request still asserted in the cycle after host_ready starts a new transaction; back-to-back transactions are therefore possible.
- Latency:
  - Request at cycle 0, strobe at 1, device ready at k≥1 → host_ready at k+1.
  - Unmapped address → host_ready at cycle 1.

Test Plan:
- Read 0x0000_0010, dev0 active, dev0 ready at cycle 2 with data 0xDEADBEEF → device_ren=0b0001 during cycles 1-2; host_ready at cycle 3 with rdata 0xDEADBEEF, error=0.
- Write 0x1000_0004, data 0x12345678, mask 0b0011, dev2 active → device_wen[2]=1 with latched mask 0b0011; host_ready with error=0 and rdata=0; no other strobe ever high.
- Read with device_active all 0 → host_ready at cycle 1, error=1, rdata=0; err_count 0→1; no device strobe.
- TIMEOUT=8, dev1 never ready → strobe held 8 cycles then dropped; host_ready with error=1; a late device_ready[1] after that is ignored.
- dev1 and dev3 both active → only dev1 strobed; ready pulses from dev3 are ignored.
- Reset asserted during BUSY → strobes 0 immediately (asynchronous), no host_ready; after release, a fresh read completes normally. err_count saturates at 255 after 300 unmapped reads.

Source files
------------

// File: rtl/bus_hub_n.sv
// -----------------------------------------------------------------------------
// bus_hub_n
//
// Connects one host bus (the CPU data port) to NDEV memory-mapped devices and
// carries one transaction at a time. Devices decode the broadcast address
// themselves and report hits on device_active. The hub picks the
// lowest-index hit as the target and runs the strobe/ready handshake with it.
// It then returns a one-cycle registered response to the host.
//
// Addresses that no device claims get an error response. A device that never
// answers also gets an error response, once TIMEOUT cycles pass. Every error
// response advances a saturating counter.
//
// Parameters
//   NDEV     number of device ports (2..16)
//   TIMEOUT  cycles allowed from device strobe to device_ready; 0 disables
//   ERRW     width of the error counter
//
// Ports
//   clk                clock, rising edge
//   rst                asynchronous active-low reset
//   host_address       byte address from the host
//   host_data_write    host write data
//   host_write_mask    host byte enables
//   host_wen/host_ren  host write/read request (write wins if both are set)
//   host_data_read     read data, valid while host_ready is high, else 0
//   host_ready         one-cycle completion pulse
//   host_error         qualifies host_ready: unmapped address or timeout
//   device_address     address broadcast to every device slice
//   device_data_write  write data broadcast to every device slice
//   device_write_mask  byte enables broadcast to every device slice
//   device_ren         per-device read strobe (at most one bit high)
//   device_wen         per-device write strobe (at most one bit high)
//   device_ready       per-device completion
//   device_data_read   per-device read data
//   device_active      per-device decode hit for the current device_address
//   err_count          saturating count of error responses
// -----------------------------------------------------------------------------
module bus_hub_n #(
   parameter int NDEV    = 4,
   parameter int TIMEOUT = 64,
   parameter int ERRW    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          host_address,
   input  logic [31:0]          host_data_write,
   input  logic [3:0]           host_write_mask,
   input  logic                 host_wen,
   input  logic                 host_ren,
   output logic [31:0]          host_data_read,
   output logic                 host_ready,
   output logic                 host_error,
   output logic [NDEV*32-1:0]   device_address,
   output logic [NDEV*32-1:0]   device_data_write,
   output logic [NDEV*4-1:0]    device_write_mask,
   output logic [NDEV-1:0]      device_ren,
   output logic [NDEV-1:0]      device_wen,
   input  logic [NDEV-1:0]      device_ready,
   input  logic [NDEV*32-1:0]   device_data_read,
   input  logic [NDEV-1:0]      device_active,
   output logic [ERRW-1:0]      err_count
);

   localparam int SW = (NDEV > 1) ? $clog2(NDEV) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      mask_q, mask_d;
   logic            wr_q, wr_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            err_q, err_d;
   logic [ERRW-1:0] err_count_q, err_count_d;

   logic [SW-1:0]   hit_idx;
   logic            hit_any;
   logic [31:0]     dev_rdata [NDEV];
   logic            sel_ready;
   logic            timeout_hit;
   logic [31:0]     bcast_addr;
   logic [31:0]     bcast_wdata;
   logic [3:0]      bcast_mask;

   // Lowest-index priority. The loop walks downward, so the last hit it
   // records is the smallest index that decodes the address.
   always_comb begin
      hit_idx = '0;
      hit_any = 1'b0;
      for (int i = NDEV - 1; i >= 0; i--) begin
         if (device_active[i]) begin
            hit_idx = SW'(i);
            hit_any = 1'b1;
         end
      end
   end

   // Split the flat read-data bus into one word per device, so the selected
   // device's word can be picked by index.
   always_comb begin
      for (int i = 0; i < NDEV; i++) begin
         dev_rdata[i] = device_data_read[i*32 +: 32];
      end
   end

   // Only the selected device's ready is honoured; ready from any other
   // device is ignored.
   assign sel_ready = device_ready[sel_q];

   // A zero TIMEOUT turns the timeout off. Ready arriving in the expiry cycle
   // still wins, because the next-state logic tests sel_ready first.
   assign timeout_hit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

   // Devices decode live host inputs while the hub is idle. They see the
   // captured copies for the rest of the transaction.
   always_comb begin
      bcast_addr  = addr_q;
      bcast_wdata = wdata_q;
      bcast_mask  = mask_q;
      if (state_q == IDLE) begin
         bcast_addr  = host_address;
         bcast_wdata = host_data_write;
         bcast_mask  = host_write_mask;
      end
   end

   assign device_address    = {NDEV{bcast_addr}};
   assign device_data_write = {NDEV{bcast_wdata}};
   assign device_write_mask = {NDEV{bcast_mask}};

   // The strobes decode straight from the state register. An asynchronous
   // reset therefore drops them at once, and they fall the cycle after BUSY
   // ends.
   always_comb begin
      device_ren = '0;
      device_wen = '0;
      if (state_q == BUSY) begin
         if (wr_q) begin
            device_wen[sel_q] = 1'b1;
         end else begin
            device_ren[sel_q] = 1'b1;
         end
      end
   end

   // The host response comes only from registers. Read data is forced to
   // zero outside the ready pulse.
   assign host_ready     = (state_q == RESP);
   assign host_error     = (state_q == RESP) && err_q;
   assign host_data_read = (state_q == RESP) ? rdata_q : 32'd0;
   assign err_count      = err_count_q;

   // Next-state logic. The host is sampled only in IDLE. In IDLE, an unmapped
   // address goes straight to RESP with the error flag set.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mask_d      = mask_q;
      wr_d        = wr_q;
      sel_d       = sel_q;
      timer_d     = timer_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      err_count_d = err_count_q;

      case (state_q)
         IDLE: begin
            if (host_ren || host_wen) begin
               addr_d  = host_address;
               wdata_d = host_data_write;
               mask_d  = host_write_mask;
               wr_d    = host_wen;
               sel_d   = hit_idx;
               timer_d = '0;
               rdata_d = 32'd0;
               if (hit_any) begin
                  err_d   = 1'b0;
                  state_d = BUSY;
               end else begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end

         BUSY: begin
            if (sel_ready) begin
               rdata_d = wr_q ? 32'd0 : dev_rdata[sel_q];
               err_d   = 1'b0;
               state_d = RESP;
            end else if (timeout_hit) begin
               rdata_d = 32'd0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end

         RESP: begin
            if (err_q && (err_count_q != {ERRW{1'b1}})) begin
               err_count_d = err_count_q + ERRW'(1);
            end
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and capture registers. Reset clears everything, which also
   // abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         mask_q      <= 4'd0;
         wr_q        <= 1'b0;
         sel_q       <= '0;
         timer_q     <= '0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mask_q      <= mask_d;
         wr_q        <= wr_d;
         sel_q       <= sel_d;
         timer_q     <= timer_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
      end
   end

endmodule

// File: tb/tb_bus_hub_n.sv
// -----------------------------------------------------------------------------
// tb_bus_hub_n
//
// Directed bench for bus_hub_n with NDEV=4, TIMEOUT=8 and ERRW=8. Stimulus is
// applied and outputs are sampled on the falling edge. Each transaction
// starts at "cycle 0", the cycle in which the request is first presented.
// -----------------------------------------------------------------------------
module tb_bus_hub_n;

   localparam int NDEV    = 4;
   localparam int TIMEOUT = 8;
   localparam int ERRW    = 8;

   logic                clk;
   logic                rst;
   logic [31:0]         host_address;
   logic [31:0]         host_data_write;
   logic [3:0]          host_write_mask;
   logic                host_wen;
   logic                host_ren;
   logic [31:0]         host_data_read;
   logic                host_ready;
   logic                host_error;
   logic [NDEV*32-1:0]  device_address;
   logic [NDEV*32-1:0]  device_data_write;
   logic [NDEV*4-1:0]   device_write_mask;
   logic [NDEV-1:0]     device_ren;
   logic [NDEV-1:0]     device_wen;
   logic [NDEV-1:0]     device_ready;
   logic [NDEV*32-1:0]  device_data_read;
   logic [NDEV-1:0]     device_active;
   logic [ERRW-1:0]     err_count;

   int checkCount;
   int passCount;

   bus_hub_n #(.NDEV(NDEV), .TIMEOUT(TIMEOUT), .ERRW(ERRW)) dut (
      .clk               (clk),
      .rst               (rst),
      .host_address      (host_address),
      .host_data_write   (host_data_write),
      .host_write_mask   (host_write_mask),
      .host_wen          (host_wen),
      .host_ren          (host_ren),
      .host_data_read    (host_data_read),
      .host_ready        (host_ready),
      .host_error        (host_error),
      .device_address    (device_address),
      .device_data_write (device_data_write),
      .device_write_mask (device_write_mask),
      .device_ren        (device_ren),
      .device_wen        (device_wen),
      .device_ready      (device_ready),
      .device_data_read  (device_data_read),
      .device_active     (device_active),
      .err_count         (err_count)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present a host request together with the devices' decode response
   task automatic applyStimulus(input logic ren, input logic wen, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] mask,
                                input logic [NDEV-1:0] active);
      host_ren        = ren;
      host_wen        = wen;
      host_address    = addr;
      host_data_write = data;
      host_write_mask = mask;
      device_active   = active;
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   task automatic dropRequest();
      host_ren = 1'b0;
      host_wen = 1'b0;
   endtask

   int strobeCycles;
   int readyPulses;

   initial begin
      checkCount       = 0;
      passCount        = 0;
      rst              = 1'b0;
      device_ready     = '0;
      device_data_read = '0;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0000);

      // Reset state
      nextCycle();
      nextCycle();
      checkOutput("reset_ready",  {31'd0, host_ready}, 32'd0);
      checkOutput("reset_error",  {31'd0, host_error}, 32'd0);
      checkOutput("reset_rdata",  host_data_read, 32'd0);
      checkOutput("reset_errcnt", {24'd0, err_count}, 32'd0);
      checkOutput("reset_strobe", {24'd0, device_ren, device_wen}, 32'd0);
      rst = 1'b1;
      nextCycle();

      // Broadcast follows the live host address while idle
      host_address = 32'hA5A5_0000;
      #1;
      checkOutput("idle_bcast", device_address[63:32], 32'hA5A5_0000);

      // Read with device 0 ready at cycle 2
      nextCycle();
      device_data_read[31:0] = 32'hDEAD_BEEF;
      applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 4'b0001);
      nextCycle();
      checkOutput("rd_ren_c1",   {28'd0, device_ren}, 32'h1);
      checkOutput("rd_ready_c1", {31'd0, host_ready}, 32'd0);
      nextCycle();
      checkOutput("rd_ren_c2",   {28'd0, device_ren}, 32'h1);
      device_ready = 4'b0001;
      nextCycle();
      checkOutput("rd_ready_c3", {31'd0, host_ready}, 32'd1);
      checkOutput("rd_data_c3",  host_data_read, 32'hDEAD_BEEF);
      checkOutput("rd_err_c3",   {31'd0, host_error}, 32'd0);
      checkOutput("rd_ren_c3",   {28'd0, device_ren}, 32'h0);
      device_ready = '0;
      dropRequest();
      nextCycle();
      checkOutput("rd_ready_c4", {31'd0, host_ready}, 32'd0);
      checkOutput("rd_data_c4",  host_data_read, 32'd0);

      // Write to device 2; the decode changes mid-transaction to show sel is latched
      applyStimulus(1'b0, 1'b1, 32'h1000_0004, 32'h1234_5678, 4'b0011, 4'b0100);
      device_data_read[95:64] = 32'hFFFF_FFFF;
      nextCycle();
      checkOutput("wr_wen_c1",  {28'd0, device_wen}, 32'h4);
      checkOutput("wr_ren_c1",  {28'd0, device_ren}, 32'h0);
      checkOutput("wr_mask_c1", {28'd0, device_write_mask[11:8]}, 32'h3);
      checkOutput("wr_data_c1", device_data_write[95:64], 32'h1234_5678);
      checkOutput("wr_addr_c1", device_address[95:64], 32'h1000_0004);
      device_active = 4'b0001;
      nextCycle();
      checkOutput("wr_wen_c2",  {24'd0, device_ren, device_wen}, 32'h04);
      device_ready = 4'b0100;
      nextCycle();
      checkOutput("wr_ready",   {31'd0, host_ready}, 32'd1);
      checkOutput("wr_err",     {31'd0, host_error}, 32'd0);
      checkOutput("wr_rdata",   host_data_read, 32'd0);
      checkOutput("wr_strobe_off", {24'd0, device_ren, device_wen}, 32'd0);
      device_ready = '0;
      dropRequest();
      nextCycle();

      // Unmapped read: response at cycle 1 with error
      applyStimulus(1'b1, 1'b0, 32'h7000_0000, 32'h0, 4'h0, 4'b0000);
      nextCycle();
      checkOutput("um_ready", {31'd0, host_ready}, 32'd1);
      checkOutput("um_err",   {31'd0, host_error}, 32'd1);
      checkOutput("um_rdata", host_data_read, 32'd0);
      checkOutput("um_strobe", {24'd0, device_ren, device_wen}, 32'd0);
      dropRequest();
      nextCycle();
      checkOutput("um_errcnt", {24'd0, err_count}, 32'd1);
      checkOutput("um_ready_off", {31'd0, host_ready}, 32'd0);

      // Timeout on device 1: strobe for 8 cycles, then an error response
      applyStimulus(1'b1, 1'b0, 32'h2000_0000, 32'h0, 4'h0, 4'b0010);
      strobeCycles = 0;
      for (int i = 0; i < 20 && !host_ready; i++) begin
         nextCycle();
         if (device_ren == 4'b0010) strobeCycles++;
      end
      checkOutput("to_strobe_cycles", strobeCycles, 32'd8);
      checkOutput("to_ready", {31'd0, host_ready}, 32'd1);
      checkOutput("to_err",   {31'd0, host_error}, 32'd1);
      checkOutput("to_rdata", host_data_read, 32'd0);
      checkOutput("to_ren_off", {28'd0, device_ren}, 32'h0);
      dropRequest();
      device_ready = 4'b0010;
      nextCycle();
      checkOutput("to_late_ready", {31'd0, host_ready}, 32'd0);
      nextCycle();
      checkOutput("to_late_ready2", {31'd0, host_ready}, 32'd0);
      checkOutput("to_errcnt", {24'd0, err_count}, 32'd2);
      device_ready = '0;

      // Overlapping decode: dev1 beats dev3, and dev3's ready is ignored
      device_data_read[63:32]   = 32'h1111_1111;
      device_data_read[127:96]  = 32'h3333_3333;
      applyStimulus(1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'h0, 4'b1010);
      nextCycle();
      checkOutput("ov_ren_c1", {28'd0, device_ren}, 32'h2);
      device_ready = 4'b1000;
      nextCycle();
      checkOutput("ov_ready_c2", {31'd0, host_ready}, 32'd0);
      checkOutput("ov_ren_c2", {28'd0, device_ren}, 32'h2);
      device_ready = 4'b0010;
      nextCycle();
      checkOutput("ov_ready_c3", {31'd0, host_ready}, 32'd1);
      checkOutput("ov_data_c3", host_data_read, 32'h1111_1111);
      checkOutput("ov_err_c3",  {31'd0, host_error}, 32'd0);
      device_ready = '0;
      dropRequest();
      nextCycle();

      // Reset during BUSY abandons the transaction
      applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 4'b0001);
      nextCycle();
      checkOutput("rb_ren_c1", {28'd0, device_ren}, 32'h1);
      #1 rst = 1'b0;
      #1;
      checkOutput("rb_ren_async", {28'd0, device_ren}, 32'h0);
      checkOutput("rb_errcnt",    {24'd0, err_count}, 32'd0);
      dropRequest();
      nextCycle();
      checkOutput("rb_no_ready", {31'd0, host_ready}, 32'd0);
      rst = 1'b1;
      nextCycle();
      checkOutput("rb_no_ready2", {31'd0, host_ready}, 32'd0);

      // Fresh read after reset, device ready at cycle 1
      device_data_read[31:0] = 32'hCAFE_F00D;
      applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 4'b0001);
      nextCycle();
      device_ready = 4'b0001;
      nextCycle();
      checkOutput("rb_fresh_ready", {31'd0, host_ready}, 32'd1);
      checkOutput("rb_fresh_data",  host_data_read, 32'hCAFE_F00D);
      device_ready = '0;
      dropRequest();
      nextCycle();

      // 300 back-to-back unmapped reads saturate the error counter
      applyStimulus(1'b1, 1'b0, 32'h7000_0000, 32'h0, 4'h0, 4'b0000);
      readyPulses = 0;
      for (int i = 0; i < 600; i++) begin
         nextCycle();
         if (host_ready && host_error) readyPulses++;
      end
      dropRequest();
      nextCycle();
      nextCycle();
      checkOutput("sat_pulses", readyPulses, 32'd300);
      checkOutput("sat_errcnt", {24'd0, err_count}, 32'd255);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
